// File: rtl/fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared definitions for the FIFO put/get controllers: default word width,
// occupancy encoding for the 2-entry prefetch buffer, slot index type and the
// read-issue helper used by get_controller.
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int OCC_W              = 2;

  typedef logic [OCC_W-1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  // Which buffer slot a returning FIFO word lands in.
  typedef enum logic {
    SLOT0 = 1'b0,
    SLOT1 = 1'b1
  } slot_e;

  // A new read may be issued only if every word already owned by the buffer
  // (held, or returning from a read issued last cycle) still leaves a free
  // slot once this cycle's pop is accounted for.
  function automatic logic issue_ok(input occ_t occ, input logic inflight,
                                    input logic pop);
    logic [OCC_W:0] pending;
    pending = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};
    return pending < {1'b0, OCC_FULL};
  endfunction

endpackage

// File: rtl/get_controller_if.sv
// -----------------------------------------------------------------------------
// get_controller_if
// Bundles the FIFO read port and the downstream valid/ready stream seen by
// get_controller.
//   empty      FIFO empty flag (same-cycle)
//   fifo_rdata FIFO read data, valid the cycle after en_get
//   en_get     FIFO read enable, one pop per high cycle
//   out_valid  out_data holds a valid word
//   out_data   head word of the prefetch buffer
//   out_ready  consumer accepts the word this cycle
//   occupancy  words currently held in the prefetch buffer (0-2)
// master: the controller's view.  slave: the FIFO + consumer view.
// -----------------------------------------------------------------------------
interface get_controller_if #(
  parameter int DATA_WIDTH = fifo_ctrl_pkg::DEFAULT_DATA_WIDTH
);

  logic                    empty;
  logic [DATA_WIDTH-1:0]   fifo_rdata;
  logic                    en_get;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_ready;
  fifo_ctrl_pkg::occ_t     occupancy;

  modport master (
    input  empty, fifo_rdata, out_ready,
    output en_get, out_valid, out_data, occupancy
  );

  modport slave (
    output empty, fifo_rdata, out_ready,
    input  en_get, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/get_skid_buffer.sv
// -----------------------------------------------------------------------------
// get_skid_buffer
// Two-entry in-order prefetch buffer. slot0 is always the head word. A pop
// shifts slot1 into slot0; a push writes the slot at index (occ - pop), i.e.
// the first free slot after the pop shift, so pop and push in the same cycle
// keep strict FIFO order.
//   clk, reset  clock, synchronous active-high reset
//   push        capture push_data this cycle
//   push_data   word returning from the FIFO
//   pop         consumer takes the head word this cycle (only while occ != 0)
//   head        current head word (registered slot0)
//   occ         number of words held (0-2)
// -----------------------------------------------------------------------------
module get_skid_buffer
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  occ_t                  wr_idx;
  slot_e                 wr_slot;

  always_comb begin
    wr_idx  = occ - occ_t'(pop);
    wr_slot = (wr_idx == OCC_EMPTY) ? SLOT0 : SLOT1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only two slots, so they are cleared too; head then reads 0 out
      // of reset instead of X.
      slot0 <= '0;
      slot1 <= '0;
      occ   <= OCC_EMPTY;
    end else begin
      if (pop) begin
        slot0 <= slot1;
      end
      // NOTE: the capture below may target slot0 in the same cycle as the
      // shift above; the later non-blocking assignment wins, which is exactly
      // the "pop + push with one word held" case.
      if (push) begin
        case (wr_slot)
          SLOT0:   slot0 <= push_data;
          SLOT1:   slot1 <= push_data;
          default: slot0 <= push_data;
        endcase
      end
      occ <= occ + occ_t'(push) - occ_t'(pop);
    end
  end

  assign head = slot0;

endmodule

// File: rtl/get_controller.sv
// -----------------------------------------------------------------------------
// get_controller
// Read side of the FIFO controller pair. Issues FIFO read enables while the
// FIFO is non-empty and the prefetch buffer can absorb the word that returns
// one cycle later, and presents buffered words to the consumer over a
// valid/ready handshake at one word per cycle.
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    get_controller_if.master: empty, fifo_rdata, out_ready in;
//          en_get, out_valid, out_data, occupancy out
// -----------------------------------------------------------------------------
module get_controller
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  get_controller_if.master bus
);

  logic                  inflight;
  logic                  pop;
  occ_t                  occ;
  logic [DATA_WIDTH-1:0] head;

  // out_valid comes straight from the occ register, so the handshake output
  // carries no combinational path from any input.
  assign bus.out_valid = (occ != OCC_EMPTY);
  assign pop           = bus.out_valid & bus.out_ready;

  // out_ready -> pop -> en_get is the one intended combinational path: it lets
  // a read be issued in the same cycle a pop frees a slot, which is what keeps
  // the stream bubble-free.
  assign bus.en_get = ~bus.empty & ~reset & issue_ok(occ, inflight, pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
    end else begin
      inflight <= bus.en_get;
    end
  end

  // A word returning while reset is high is dropped: the buffer's reset has
  // priority over the capture, and the FIFO is reset alongside this block.
  get_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (bus.fifo_rdata),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  assign bus.out_data  = head;
  assign bus.occupancy = occ;

endmodule

// File: tb/tb_get_controller.sv
// -----------------------------------------------------------------------------
// tb_get_controller
// Self-checking bench for get_controller: a behavioural FIFO with one-cycle
// read latency feeds the DUT, words are pushed onto a scoreboard queue as they
// are written into the FIFO and popped/compared when the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_get_controller;
  import fifo_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int FIFO_DEPTH = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  get_controller_if #(.DATA_WIDTH(DW)) bus ();

  get_controller #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // ---------------- behavioural FIFO ----------------
  logic [DW-1:0] fifo_mem [FIFO_DEPTH];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          hold_empty = 1'b0;

  assign bus.empty = (rd_ptr == wr_ptr) || hold_empty;

  always @(posedge clk) begin
    if (reset) begin
      rd_ptr         <= wr_ptr;
      bus.fifo_rdata <= '0;
    end else if (bus.en_get) begin
      bus.fifo_rdata <= fifo_mem[rd_ptr % FIFO_DEPTH];
      rd_ptr         <= rd_ptr + 1;
    end
  end

  // Bench-side copy of "a read was issued last cycle".
  logic tb_inflight = 1'b0;
  always @(posedge clk) tb_inflight <= reset ? 1'b0 : bus.en_get;

  // ---------------- scoreboard / checking ----------------
  logic [DW-1:0] exp_q[$];
  int            pass_cnt = 0;
  int            total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_mem[wr_ptr % FIFO_DEPTH] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;
  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      check("occ_plus_inflight_le_2",
            32'(({1'b0, bus.occupancy} + {2'b0, tb_inflight}) <= 3'd2), 1);
      if (hold_v) begin
        check("stall_valid_held", bus.out_valid, 1);
        check("stall_data_held", bus.out_data, hold_d);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("scoreboard_has_word", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("stream_word", bus.out_data, exp_q.pop_front());
      end
      hold_v = bus.out_valid & ~bus.out_ready;
      hold_d = bus.out_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic          ready;
    logic          en;
    logic          valid;
    logic [DW-1:0] data;
    occ_t          occ;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int cnt;
    int n;
    int pushed;

    // Preloaded 0x11/0x22/0x33 with out_ready high; row i is cycle i after
    // the FIFO turns non-empty.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, OCC_EMPTY};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, OCC_EMPTY};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h11, OCC_ONE};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h22, OCC_ONE};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h33, OCC_ONE};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, OCC_EMPTY};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, OCC_EMPTY};

    bus.out_ready = 1'b0;

    // ---- reset state ----
    repeat (3) step();
    @(negedge clk);
    check("reset_en_get", bus.en_get, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_occupancy", bus.occupancy, 0);
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    step();

    // ---- latency / throughput table ----
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    for (int i = 0; i < 7; i++) begin
      bus.out_ready = tbl[i].ready;
      @(negedge clk);
      check($sformatf("tbl%0d_en_get", i), bus.en_get, tbl[i].en);
      check($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].valid);
      check($sformatf("tbl%0d_occupancy", i), bus.occupancy, tbl[i].occ);
      if (tbl[i].valid) check($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].data);
      step();
    end
    check("tbl_drained", exp_q.size(), 0);

    // ---- backpressure: 5 words, out_ready low ----
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h40 + 8'(i));
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.en_get) cnt++;
      step();
    end
    check("bp_en_get_pulses", cnt, 2);
    @(negedge clk);
    check("bp_occupancy_full", bus.occupancy, 2);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_same_cycle", bus.en_get, 1);
    wait_drain("bp_drained", 100);
    repeat (3) step();

    // ---- out_ready toggling every cycle, 16 words ----
    for (int i = 0; i < 16; i++) push_word(8'h80 + 8'(i));
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      bus.out_ready = ~bus.out_ready;
      step();
      n++;
    end
    check("toggle_drained", exp_q.size(), 0);
    bus.out_ready = 1'b1;
    repeat (3) step();

    // ---- FIFO empty throughout ----
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_en_get", bus.en_get, 0);
      check("idle_out_valid", bus.out_valid, 0);
      check("idle_occupancy", bus.occupancy, 0);
      step();
    end

    // ---- reset one cycle after en_get with occ = 1 ----
    bus.out_ready = 1'b0;
    push_word(8'hA1);
    n = 0;
    do begin
      step();
      @(negedge clk);
      n++;
    end while (bus.occupancy != OCC_ONE && n < 10);
    check("rst_setup_occ1", bus.occupancy, 1);
    step();
    push_word(8'hA2);
    @(negedge clk);
    check("rst_en_get_issued", bus.en_get, 1);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rst_en_get_forced_low", bus.en_get, 0);
    step();
    @(negedge clk);
    check("rst_occupancy_cleared", bus.occupancy, 0);
    check("rst_out_valid_cleared", bus.out_valid, 0);
    exp_q.delete();
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("rst_word_not_captured_occ", bus.occupancy, 0);
    check("rst_word_not_captured_valid", bus.out_valid, 0);
    step();

    // ---- random empty/ready stress, 1000 words ----
    pushed = 0;
    n = 0;
    while ((pushed < 1000 || exp_q.size() != 0) && n < 20000) begin
      if (pushed < 1000 && ($urandom % 2) == 0) begin
        push_word(8'($urandom_range(0, 255)));
        pushed++;
      end
      bus.out_ready = ($urandom % 4) != 0;
      hold_empty    = ($urandom % 4) == 0;
      step();
      n++;
    end
    hold_empty = 1'b0;
    bus.out_ready = 1'b1;
    check("stress_all_pushed", pushed, 1000);
    wait_drain("stress_drained", 50);
    repeat (3) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
